// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and single-outstanding instruction fetch stage.
// Optional perf counters enabled by defining IF_PERF_CNT_EN.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_write,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instruction_out,
   output logic [31:0] PCplus4_out,
   output logic        fetch_valid,
`ifdef IF_PERF_CNT_EN
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt,
`endif
   output logic        Flush
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_instr;
   logic [31:0] w_instr_nxt;
   logic [31:0] r_pcp4;
   logic [31:0] w_pcp4_nxt;
   logic        r_valid;
   logic        w_valid_nxt;
   logic        r_kill;
   logic        w_kill_nxt;
   logic [31:0] w_target;
   logic [31:0] w_pc_plus4;
   logic        w_outstanding;

   assign w_target   = redirect_target & ~32'd3;
   assign w_pc_plus4 = r_pc + 32'd4;

   // A request is in flight if it issues now or is still awaiting its response.
   assign w_outstanding = (r_state == S_FETCH) ||
                          ((r_state == S_WAIT) && !imem_rvalid);

   assign imem_req        = (r_state == S_FETCH);
   assign imem_addr       = r_pc;
   assign Instruction_out = r_instr;
   assign PCplus4_out     = r_pcp4;
   assign fetch_valid     = r_valid;
   assign Flush           = redirect;

   // Next-state logic: fetch sequencing, then redirect overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_instr_nxt = r_instr;
      w_pcp4_nxt  = r_pcp4;
      w_valid_nxt = r_valid;
      w_kill_nxt  = r_kill;

      unique case (r_state)
         S_IDLE: begin
            w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (r_kill) begin
                  w_kill_nxt  = 1'b0;
                  w_state_nxt = S_FETCH;
               end else begin
                  w_instr_nxt = imem_rdata;
                  w_pcp4_nxt  = w_pc_plus4;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (pc_write) begin
               w_valid_nxt = 1'b0;
               w_pc_nxt    = w_pc_plus4;
               w_instr_nxt = NOP_INSTR;
               w_pcp4_nxt  = 32'd0;
               w_state_nxt = S_FETCH;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (redirect) begin
         w_pc_nxt    = w_target;
         w_valid_nxt = 1'b0;
         w_instr_nxt = NOP_INSTR;
         w_pcp4_nxt  = 32'd0;
         if (w_outstanding) begin
            w_kill_nxt  = 1'b1;
            w_state_nxt = S_WAIT;
         end else begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_FETCH;
         end
      end
   end

   // State, PC and output buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_instr <= NOP_INSTR;
         r_pcp4  <= 32'd0;
         r_valid <= 1'b0;
         r_kill  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_instr <= w_instr_nxt;
         r_pcp4  <= w_pcp4_nxt;
         r_valid <= w_valid_nxt;
         r_kill  <= w_kill_nxt;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_stall_cnt;
   logic        w_consume;
   logic        w_stall;

   assign w_consume = (r_state == S_HOLD) && pc_write && !redirect;
   assign w_stall   = r_valid && !pc_write;

   assign perf_fetch_cnt = r_fetch_cnt;
   assign perf_stall_cnt = r_stall_cnt;

   // Consumed-word and stalled-cycle counters, free-running with wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_cnt <= 32'd0;
         r_stall_cnt <= 32'd0;
      end else begin
         if (w_consume) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
         if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end
`else
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed + random checks of if_fetch_unit
// against a transaction-level fetch model and variable-latency memory.
module tb_if_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0000;
   localparam logic [31:0] TOP = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        pc_write = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] Instruction_out;
   logic [31:0] PCplus4_out;
   logic        fetch_valid;
   logic        Flush;

   logic        imem_req2;
   logic [31:0] imem_addr2;
   logic        imem_rvalid2 = 1'b0;
   logic [31:0] imem_rdata2 = 32'd0;
   logic [31:0] Instruction_out2;
   logic [31:0] PCplus4_out2;
   logic        fetch_valid2;
   logic        Flush2;

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_fetch_cnt2;
   logic [31:0] perf_stall_cnt2;
`endif

   always #5 clk = ~clk;

   if_fetch_unit u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pc_write        (pc_write),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .Instruction_out (Instruction_out),
      .PCplus4_out     (PCplus4_out),
      .fetch_valid     (fetch_valid),
`ifdef IF_PERF_CNT_EN
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_stall_cnt  (perf_stall_cnt),
`endif
      .Flush           (Flush)
   );

   if_fetch_unit #(.RESET_PC(TOP)) u_dut2 (
      .clk             (clk),
      .rst_n           (rst_n),
      .pc_write        (pc_write),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_req        (imem_req2),
      .imem_addr       (imem_addr2),
      .imem_rvalid     (imem_rvalid2),
      .imem_rdata      (imem_rdata2),
      .Instruction_out (Instruction_out2),
      .PCplus4_out     (PCplus4_out2),
      .fetch_valid     (fetch_valid2),
`ifdef IF_PERF_CNT_EN
      .perf_fetch_cnt  (perf_fetch_cnt2),
      .perf_stall_cnt  (perf_stall_cnt2),
`endif
      .Flush           (Flush2)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: next instruction address to deliver, buffer contents.
   logic [31:0] m_pc;
   logic [31:0] m_out;
   logic [31:0] m_pp4;
   logic        m_valid;
   logic        m_due;
   logic        m_idle;
   logic [31:0] m_fcnt;
   logic [31:0] m_scnt;
   // Memory for main DUT: one outstanding request, programmable latency.
   logic        mem_busy;
   logic        mem_stale;
   logic [31:0] mem_addr;
   int          mem_cnt;
   int          lat;
   // One-cycle memory for second DUT.
   logic        p2_rv;
   logic [31:0] p2_addr;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cycle(input logic rd, input logic [31:0] tgt,
                        input logic pw, input logic spur);
      logic        v_rv;
      logic        s_req;
      logic [31:0] s_addr;
      logic        s_req2;
      logic [31:0] s_addr2;
      logic        pv;
      logic        nd;
      redirect        = rd;
      redirect_target = tgt;
      pc_write        = pw;
      v_rv            = mem_busy && (mem_cnt == 0);
      imem_rvalid     = v_rv || (spur && !mem_busy);
      imem_rdata      = v_rv ? memfn(mem_addr) : $urandom();
      imem_rvalid2    = p2_rv;
      imem_rdata2     = memfn(p2_addr);
      #1;
      chk("flush", {31'd0, Flush}, {31'd0, rd});
      s_req   = imem_req;
      s_addr  = imem_addr;
      s_req2  = imem_req2;
      s_addr2 = imem_addr2;
      if (s_req) chk("req_addr", s_addr, m_pc);
      @(posedge clk);
      p2_rv   = s_req2;
      p2_addr = s_addr2;
      pv = m_valid;
      nd = 1'b0;
      if (pv && !pw) m_scnt = m_scnt + 32'd1;
      if (m_idle) begin
         m_idle = 1'b0;
         nd = 1'b1;
      end
      if (v_rv) begin
         mem_busy = 1'b0;
         if (!mem_stale && !rd) begin
            m_valid = 1'b1;
            m_out   = memfn(m_pc);
            m_pp4   = m_pc + 32'd4;
         end else if (!rd) begin
            nd = 1'b1;
         end
      end else if (mem_busy && mem_cnt > 0) begin
         mem_cnt--;
      end
      if (s_req) begin
         mem_busy  = 1'b1;
         mem_addr  = s_addr;
         mem_cnt   = lat - 1;
         mem_stale = 1'b0;
      end
      if (rd) begin
         m_pc    = tgt & ~32'd3;
         m_valid = 1'b0;
         m_out   = NOP;
         m_pp4   = 32'd0;
         if (mem_busy) mem_stale = 1'b1;
         else nd = 1'b1;
      end else if (pw && pv) begin
         m_valid = 1'b0;
         m_pc    = m_pc + 32'd4;
         m_out   = NOP;
         m_pp4   = 32'd0;
         m_fcnt  = m_fcnt + 32'd1;
         nd = 1'b1;
      end
      m_due = nd;
      @(negedge clk);
      chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_valid});
      chk("instr", Instruction_out, m_out);
      chk("pcplus4", PCplus4_out, m_pp4);
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_due});
`ifdef IF_PERF_CNT_EN
      chk("perf_fetch", perf_fetch_cnt, m_fcnt);
      chk("perf_stall", perf_stall_cnt, m_scnt);
`endif
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
      chk("rst_instr", Instruction_out, NOP);
      chk("rst_pcp4", PCplus4_out, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid2", {31'd0, fetch_valid2}, 32'd0);
`ifdef IF_PERF_CNT_EN
      chk("rst_pf", perf_fetch_cnt, 32'd0);
      chk("rst_ps", perf_stall_cnt, 32'd0);
`endif
      redirect = 1'b0;
      pc_write = 1'b0;
      imem_rvalid = 1'b0;
      imem_rvalid2 = 1'b0;
      m_pc = 32'd0;
      m_out = NOP;
      m_pp4 = 32'd0;
      m_valid = 1'b0;
      m_due = 1'b0;
      m_idle = 1'b1;
      m_fcnt = 32'd0;
      m_scnt = 32'd0;
      mem_busy = 1'b0;
      mem_stale = 1'b0;
      mem_addr = 32'd0;
      mem_cnt = 0;
      p2_rv = 1'b0;
      p2_addr = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      lat = 1;
      #2;
      do_reset();

      // Back-to-back fetches with single-cycle memory.
      for (int i = 0; i < 9; i++) begin
         cycle(1'b0, 32'd0, 1'b1, 1'b0);
         if (i == 0) begin
            chk("d2_req0", {31'd0, imem_req2}, 32'd1);
            chk("d2_addr0", imem_addr2, TOP);
         end
         if (i == 2) begin
            chk("first_pcp4", PCplus4_out, 32'd4);
            chk("d2_valid", {31'd0, fetch_valid2}, 32'd1);
            chk("d2_pcp4_wrap", PCplus4_out2, 32'd0);
            chk("d2_instr", Instruction_out2, memfn(TOP));
         end
         if (i == 3) begin
            chk("d2_req1", {31'd0, imem_req2}, 32'd1);
            chk("d2_addr_wrap", imem_addr2, 32'd0);
         end
      end

      // Stall with word at 0x10 buffered.
      for (int k = 0; k < 40 && !(m_valid && m_pc == 32'h10); k++)
         cycle(1'b0, 32'd0, 1'b1, 1'b0);
      chk("at_0x10", PCplus4_out, 32'h14);
      repeat (5) begin
         cycle(1'b0, 32'd0, 1'b0, 1'b0);
         chk("stall_pcp4", PCplus4_out, 32'h14);
         chk("stall_noreq", {31'd0, imem_req}, 32'd0);
      end
      cycle(1'b0, 32'd0, 1'b1, 1'b0);
      chk("release_req", {31'd0, imem_req}, 32'd1);
      chk("release_addr", imem_addr, 32'h14);

      // Redirect while waiting on a 3-cycle memory.
      lat = 3;
      for (int k = 0; k < 20 && !(mem_busy && mem_cnt > 0); k++)
         cycle(1'b0, 32'd0, 1'b1, 1'b0);
      cycle(1'b1, 32'h103, 1'b1, 1'b0);
      chk("redir_valid", {31'd0, fetch_valid}, 32'd0);
      for (int k = 0; k < 10 && imem_req !== 1'b1; k++)
         cycle(1'b0, 32'd0, 1'b1, 1'b0);
      chk("redir_req", {31'd0, imem_req}, 32'd1);
      chk("redir_addr", imem_addr, 32'h100);

      // Redirect landing on the response cycle.
      lat = 2;
      for (int k = 0; k < 20 && !(mem_busy && mem_cnt == 0 && !mem_stale);
           k++)
         cycle(1'b0, 32'd0, 1'b1, 1'b0);
      cycle(1'b1, 32'h200, 1'b0, 1'b0);
      chk("coinc_req", {31'd0, imem_req}, 32'd1);
      chk("coinc_addr", imem_addr, 32'h200);
      chk("coinc_valid", {31'd0, fetch_valid}, 32'd0);

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         logic        rd;
         logic [31:0] tgt;
         lat = $urandom_range(1, 4);
         rd  = ($urandom_range(0, 9) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom();
         cycle(rd, tgt, ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 7) == 0));
      end

      // Reset while a request is outstanding.
      lat = 4;
      for (int k = 0; k < 20 && !(mem_busy && mem_cnt > 0); k++)
         cycle(1'b0, 32'd0, 1'b1, 1'b0);
      #3;
      do_reset();
      lat = 1;
      cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("post_rst_req", {31'd0, imem_req}, 32'd1);
      chk("post_rst_addr", imem_addr, 32'd0);
      repeat (8) cycle(1'b0, 32'd0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
